// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - pipeline data-memory stage with byte-lane stores, 2-deep result queue and side read port
module data_mem_stage #(
  parameter int XLEN   = 32,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 18
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mem_to_reg,
  input  logic                mem_write_en,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  input  logic                side_req,
  input  logic [ADDR_W-1:0]   side_addr,
  output logic                side_valid,
  output logic [DATA_W-1:0]   side_data
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  // Reject RAM widths that cannot be split into whole byte lanes or do not fit the pipeline word
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > XLEN) begin : g_bad_data_w
    $error("data_mem_stage: DATA_W must be a non-zero multiple of 8 and <= XLEN");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [XLEN-1:0]   fifo_q [2];
  logic              in_ready_q;

  logic              accept;
  logic              deliver;
  logic              is_store;
  logic              is_load;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_word;
  logic [XLEN-1:0]   entry;

  // Upper address and store-data bits are intentionally ignored; addresses wrap modulo depth
  logic [XLEN-1:0]   unused_hi_bits;
  assign unused_hi_bits = (alu_result >> ADDR_W) ^ (write_data >> DATA_W);

  assign addr      = alu_result[ADDR_W-1:0];
  assign is_store  = mem_write_en;
  assign is_load   = mem_to_reg & ~mem_write_en;
  assign in_ready  = in_ready_q;
  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid & in_ready_q;
  assign deliver   = out_valid & out_ready;
  assign result    = fifo_q[rd_ptr];

  // Result to queue: zero-extended RAM word for loads, alu_result for stores and pass-through
  always_comb begin
    rd_word = mem[addr];
    entry   = alu_result;
    if (is_load) begin
      entry              = '0;
      entry[DATA_W-1:0]  = rd_word;
    end
  end

  // Occupancy update from accept/deliver pair
  always_comb begin
    occ_next = occ;
    case ({accept, deliver})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // RAM byte-lane writes; contents survive reset, and in_ready=0 in reset blocks any write
  always_ff @(posedge CLK) begin
    if (accept && is_store) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[addr][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  // Result queue, pointers, occupancy and registered in_ready
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      occ        <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      if (accept) begin
        fifo_q[wr_ptr] <= entry;
        wr_ptr         <= ~wr_ptr;
      end
      if (deliver) rd_ptr <= ~rd_ptr;
      occ        <= occ_next;
      in_ready_q <= (occ_next != 2'd2);
    end
  end

  // Side read port: registered read of the pre-edge RAM contents, data held when idle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      side_valid <= 1'b0;
      side_data  <= '0;
    end else begin
      side_valid <= side_req;
      if (side_req) side_data <= mem[side_addr];
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed self-checking bench for data_mem_stage
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mem_to_reg;
  logic        mem_write_en;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [2:0]  byte_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        side_req;
  logic [17:0] side_addr;
  logic        side_valid;
  logic [23:0] side_data;

  int tests = 0;
  int fails = 0;

  data_mem_stage #(.XLEN(32), .DATA_W(24), .ADDR_W(18)) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_to_reg   (mem_to_reg),
    .mem_write_en (mem_write_en),
    .alu_result   (alu_result),
    .write_data   (write_data),
    .byte_en      (byte_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .side_req     (side_req),
    .side_addr    (side_addr),
    .side_valid   (side_valid),
    .side_data    (side_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] be);
    in_valid     = 1'b1;
    mem_to_reg   = ld;
    mem_write_en = st;
    alu_result   = a;
    write_data   = d;
    byte_en      = be;
  endtask

  task automatic idle;
    in_valid     = 1'b0;
    mem_to_reg   = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; out_ready = 1'b1; side_req = 1'b1; side_addr = 18'd5;
    set_op(1'b0, 1'b1, 32'd5, 32'h00777777, 3'b111);
    tick; tick;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
    tests++; if (side_valid !== 1'b0 || side_data !== 24'h0) begin fails++; $display("FAIL reset_side got=%0b/%h exp=0/0", side_valid, side_data); end
    idle; side_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_store_load;
    set_op(1'b0, 1'b1, 32'd5, 32'h00A1B2C3, 3'b111);
    tick;
    tests++; if (out_valid !== 1'b1 || result !== 32'h00000005) begin fails++; $display("FAIL store_result got=%0b/%h exp=1/00000005", out_valid, result); end
    set_op(1'b1, 1'b0, 32'd5, 32'h0, 3'b000);
    tick;
    tests++; if (out_valid !== 1'b1 || result !== 32'h00A1B2C3) begin fails++; $display("FAIL load_after_store got=%0b/%h exp=1/00A1B2C3", out_valid, result); end
    idle; tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_byte_lane;
    set_op(1'b0, 1'b1, 32'd5, 32'h00FFFFFF, 3'b010);
    tick;
    tests++; if (result !== 32'h00000005) begin fails++; $display("FAIL lane_store_result got=%h exp=00000005", result); end
    set_op(1'b1, 1'b0, 32'd5, 32'h0, 3'b000);
    tick;
    tests++; if (result !== 32'h00A1FFC3) begin fails++; $display("FAIL lane_load got=%h exp=00A1FFC3", result); end
    set_op(1'b1, 1'b0, 32'h00040005, 32'h0, 3'b000);
    tick;
    tests++; if (result !== 32'h00A1FFC3) begin fails++; $display("FAIL addr_wrap_load got=%h exp=00A1FFC3", result); end
    idle; tick;
  endtask

  task automatic test_op_decode;
    set_op(1'b0, 1'b0, 32'hDEADBEEF, 32'h00111111, 3'b111);
    tick;
    tests++; if (result !== 32'hDEADBEEF) begin fails++; $display("FAIL passthrough got=%h exp=DEADBEEF", result); end
    set_op(1'b1, 1'b1, 32'd7, 32'hFF123456, 3'b111);
    tick;
    tests++; if (result !== 32'h00000007) begin fails++; $display("FAIL both_set_is_store got=%h exp=00000007", result); end
    set_op(1'b1, 1'b0, 32'd7, 32'h0, 3'b000);
    tick;
    tests++; if (result !== 32'h00123456) begin fails++; $display("FAIL both_set_load got=%h exp=00123456", result); end
    idle; tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    set_op(1'b0, 1'b0, 32'h11, 32'h0, 3'b000);
    tick;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after1 got=%0b exp=1", in_ready); end
    set_op(1'b0, 1'b0, 32'h22, 32'h0, 3'b000);
    tick;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_after2 got=%0b exp=0", in_ready); end
    set_op(1'b0, 1'b0, 32'h33, 32'h0, 3'b000);
    tick;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h11) begin fails++; $display("FAIL bp_hold got=%0b/%0b/%h exp=0/1/00000011", in_ready, out_valid, result); end
    out_ready = 1'b1;
    tick;
    tests++; if (result !== 32'h22 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_second got=%h/%0b exp=00000022/1", result, in_ready); end
    tick;
    tests++; if (result !== 32'h33 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_third got=%0b/%h exp=1/00000033", out_valid, result); end
    idle; tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] model [8];
    logic [31:0] exp;
    logic [31:0] a;
    logic [23:0] d;
    logic [2:0]  be;
    int          kind;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a    = 32'd100 + (k % 8);
      d    = 24'(k * 32'h010203) ^ 24'hA5A5A5;
      kind = (k < 8) ? 0 : (k % 3);
      be   = (k < 8) ? 3'b111 : 3'((k % 7) + 1);
      if (kind == 0) begin
        set_op(1'b0, 1'b1, a, {8'hEE, d}, be);
        for (int i = 0; i < 3; i++) if (be[i]) model[k % 8][8*i +: 8] = d[8*i +: 8];
        exp = a;
      end else if (kind == 1) begin
        set_op(1'b1, 1'b0, a, 32'h0, 3'b000);
        exp = {8'h00, model[k % 8]};
      end else begin
        set_op(1'b0, 1'b0, {d, 8'h5A}, 32'h0, 3'b000);
        exp = {d, 8'h5A};
      end
      tick;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || result !== exp) begin
        fails++;
        $display("FAIL b2b_op%0d got=%0b/%0b/%h exp=1/1/%h", k, in_ready, out_valid, result, exp);
      end
    end
    idle; tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_side_port;
    out_ready = 1'b1;
    set_op(1'b0, 1'b1, 32'd5, 32'h00445566, 3'b111);
    side_req = 1'b1; side_addr = 18'd5;
    tick;
    tests++; if (side_valid !== 1'b1 || side_data !== 24'hA1FFC3) begin fails++; $display("FAIL side_old got=%0b/%h exp=1/a1ffc3", side_valid, side_data); end
    idle;
    tick;
    tests++; if (side_valid !== 1'b1 || side_data !== 24'h445566) begin fails++; $display("FAIL side_new got=%0b/%h exp=1/445566", side_valid, side_data); end
    side_req = 1'b0;
    tick;
    tests++; if (side_valid !== 1'b0 || side_data !== 24'h445566) begin fails++; $display("FAIL side_hold got=%0b/%h exp=0/445566", side_valid, side_data); end
  endtask

  task automatic test_reset_midop;
    out_ready = 1'b0;
    set_op(1'b1, 1'b0, 32'd5, 32'h0, 3'b000);
    tick;
    set_op(1'b0, 1'b0, 32'h99, 32'h0, 3'b000);
    tick;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL full_before_reset got=%0b/%0b exp=0/1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin fails++; $display("FAIL async_reset got=%0b/%0b/%h exp=0/0/0", in_ready, out_valid, result); end
    set_op(1'b0, 1'b1, 32'd5, 32'h00999999, 3'b111);
    tick; tick;
    idle;
    @(negedge clk); rst_n = 1'b1;
    tick;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL post_reset got=%0b/%0b exp=1/0", in_ready, out_valid); end
    out_ready = 1'b1;
    set_op(1'b1, 1'b0, 32'd5, 32'h0, 3'b000);
    tick;
    tests++; if (out_valid !== 1'b1 || result !== 32'h00445566) begin fails++; $display("FAIL ram_kept got=%0b/%h exp=1/00445566", out_valid, result); end
    idle; tick;
  endtask

  initial begin
    idle;
    alu_result = '0; write_data = '0; byte_en = '0;
    test_reset;
    test_store_load;
    test_byte_lane;
    test_op_decode;
    test_backpressure;
    test_back_to_back;
    test_side_port;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
